// File: rtl/adc_axis_scanner.sv
// Round-robin ADC channel scanner: latches 12-bit samples, derives hysteretic +/- flags, snapshots them per frame.
// Latency: accepted response -> samples/live flags next edge; snapshot on the new_frame edge. Stalls in ISSUE until cmd_ready.
module adc_axis_scanner #(
    parameter int NUM_CH   = 2,
    parameter int FIRST_CH = 1,
    parameter int HI_TH    = 2000,
    parameter int LO_TH    = 700,
    parameter int HYST     = 64,
    parameter int TIMEOUT  = 1023
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 new_frame,
    output logic                 cmd_valid,
    output logic [4:0]           cmd_channel,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [4:0]           rsp_channel,
    input  logic [11:0]          rsp_data,
    output logic [12*NUM_CH-1:0] samples,
    output logic [NUM_CH-1:0]    dir_pos,
    output logic [NUM_CH-1:0]    dir_neg,
    output logic                 frame_strobe,
    output logic [NUM_CH-1:0]    stale,
    output logic                 timeout_err
);
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [11:0] POS_SET = 12'(HI_TH);
    localparam logic [11:0] POS_CLR = 12'(HI_TH - HYST);
    localparam logic [11:0] NEG_SET = 12'(LO_TH);
    localparam logic [11:0] NEG_CLR = 12'(LO_TH + HYST);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ADVANCE} state_t;

    state_t            state, state_nxt;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic [NUM_CH-1:0] live_pos, live_neg, refreshed;
    logic [4:0]        cur_ch;
    logic              rsp_hit, expired;

    assign cur_ch  = 5'(FIRST_CH) + 5'(idx);
    assign rsp_hit = (state == WAIT) && rsp_valid && (rsp_channel == cur_ch);
    // A matching response in the final wait cycle wins over the timeout.
    assign expired = (state == WAIT) && !rsp_hit && (cnt == CW'(TIMEOUT - 1));

    function automatic logic next_pos(input logic [11:0] s, input logic cur);
        if (s > POS_SET)      return 1'b1;
        else if (s < POS_CLR) return 1'b0;
        else                  return cur;
    endfunction

    function automatic logic next_neg(input logic [11:0] s, input logic cur);
        if (s < NEG_SET)      return 1'b1;
        else if (s > NEG_CLR) return 1'b0;
        else                  return cur;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cmd_valid   = 1'b0;
        cmd_channel = 5'd0;
        case (state)
            IDLE:    state_nxt = ISSUE;
            ISSUE: begin
                cmd_valid   = 1'b1;
                cmd_channel = cur_ch;
                if (cmd_ready) state_nxt = WAIT;
            end
            WAIT:    if (rsp_hit || expired) state_nxt = ADVANCE;
            ADVANCE: state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            idx          <= '0;
            cnt          <= '0;
            live_pos     <= '0;
            live_neg     <= '0;
            refreshed    <= '0;
            samples      <= '0;
            dir_pos      <= '0;
            dir_neg      <= '0;
            stale        <= '0;
            frame_strobe <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            frame_strobe <= new_frame;
            if (state == ISSUE && cmd_ready) cnt <= '0;
            else if (state == WAIT)          cnt <= cnt + 1'b1;
            if (state == ADVANCE)
                idx <= (idx == IW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
            if (expired) timeout_err <= 1'b1;
            // Snapshot reads the registered live flags, i.e. before any same-edge sample update.
            if (new_frame) begin
                dir_pos   <= live_pos;
                dir_neg   <= live_neg;
                stale     <= ~refreshed;
                refreshed <= '0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (rsp_hit && idx == IW'(i)) begin
                    samples[12*i +: 12] <= rsp_data;
                    live_pos[i]         <= next_pos(rsp_data, live_pos[i]);
                    live_neg[i]         <= next_neg(rsp_data, live_neg[i]);
                    refreshed[i]        <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_adc_axis_scanner.sv
// Directed bench for adc_axis_scanner: scan order, hysteresis, frame snapshots, timeout, foreign responses, reset.
module tb_adc_axis_scanner;
    localparam int NUM_CH  = 2;
    localparam int TIMEOUT = 1023;
    localparam int LIMIT   = TIMEOUT + 40;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        new_frame;
    logic        cmd_valid;
    logic [4:0]  cmd_channel;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [4:0]  rsp_channel;
    logic [11:0] rsp_data;
    logic [23:0] samples;
    logic [1:0]  dir_pos, dir_neg, stale;
    logic        frame_strobe;
    logic        timeout_err;

    int tests  = 0;
    int failed = 0;

    adc_axis_scanner #(
        .NUM_CH(NUM_CH), .FIRST_CH(1), .HI_TH(2000), .LO_TH(700), .HYST(64), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .new_frame(new_frame),
        .cmd_valid(cmd_valid), .cmd_channel(cmd_channel), .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid), .rsp_channel(rsp_channel), .rsp_data(rsp_data),
        .samples(samples), .dir_pos(dir_pos), .dir_neg(dir_neg),
        .frame_strobe(frame_strobe), .stale(stale), .timeout_err(timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clk);
    endtask

    // Waits (bounded) for a command, checks its channel, then grants it for one cycle.
    task automatic issue(input logic [4:0] ch, input string tag);
        int n = 0;
        while (!cmd_valid && n < LIMIT) begin
            step();
            n++;
        end
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 1);
        check({tag, "_cmd_channel"}, 32'(cmd_channel), 32'(ch));
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
    endtask

    task automatic respond(input logic [4:0] ch, input logic [11:0] data, input logic nf);
        rsp_valid   = 1'b1;
        rsp_channel = ch;
        rsp_data    = data;
        new_frame   = nf;
        step();
        rsp_valid   = 1'b0;
        new_frame   = 1'b0;
    endtask

    task automatic xact(input logic [4:0] ch, input logic [11:0] data, input string tag);
        issue(ch, tag);
        respond(ch, data, 1'b0);
        check({tag, "_sample"}, 32'(samples[12*(ch-1) +: 12]), 32'(data));
    endtask

    task automatic snap(input logic [1:0] ep, input logic [1:0] en, input logic [1:0] es, input string tag);
        new_frame = 1'b1;
        step();
        new_frame = 1'b0;
        check({tag, "_strobe"}, 32'(frame_strobe), 1);
        check({tag, "_dir_pos"}, 32'(dir_pos), 32'(ep));
        check({tag, "_dir_neg"}, 32'(dir_neg), 32'(en));
        check({tag, "_stale"}, 32'(stale), 32'(es));
        step();
        check({tag, "_strobe_off"}, 32'(frame_strobe), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, 32'(cmd_valid), 0);
        check({tag, "_cmd_channel"}, 32'(cmd_channel), 0);
        check({tag, "_samples"}, 32'(samples), 0);
        check({tag, "_dirs"}, 32'({dir_pos, dir_neg}), 0);
        check({tag, "_stale"}, 32'(stale), 0);
        check({tag, "_flags"}, 32'({frame_strobe, timeout_err}), 0);
    endtask

    initial begin
        reset = 1'b1; new_frame = 1'b0; cmd_ready = 1'b0;
        rsp_valid = 1'b0; rsp_channel = 5'd0; rsp_data = 12'd0;
        repeat (3) step();
        check_all_zero("reset");

        // Scan order: first command one cycle after release, then 2, 1.
        reset = 1'b0;
        step();
        check("t1_first_valid", 32'(cmd_valid), 1);
        check("t1_first_ch", 32'(cmd_channel), 1);
        repeat (3) step();
        check("t1_holds_without_ready", 32'(cmd_channel), 1);

        // Hysteresis on ch1 (pos) and ch2 (neg), observed through frame snapshots.
        xact(5'd1, 12'd2100, "t2_a1");
        xact(5'd2, 12'd1500, "t2_a2");
        snap(2'b01, 2'b00, 2'b00, "t2_snap_a");
        xact(5'd1, 12'd1990, "t2_b1");
        xact(5'd2, 12'd1500, "t2_b2");
        snap(2'b01, 2'b00, 2'b00, "t2_snap_b");
        xact(5'd1, 12'd1930, "t2_c1");
        xact(5'd2, 12'd600, "t3_c2");
        snap(2'b00, 2'b10, 2'b00, "t3_snap_c");
        xact(5'd1, 12'd1500, "t3_d1");
        xact(5'd2, 12'd770, "t3_d2");
        snap(2'b00, 2'b00, 2'b00, "t3_snap_d");

        // Timeout on ch2: sticky error, sample kept, scan moves on, ch2 reported stale.
        xact(5'd1, 12'd1500, "t4_e1");
        check("t4_no_err_yet", 32'(timeout_err), 0);
        issue(5'd2, "t4_wait_ch2");
        issue(5'd1, "t4_after_timeout");
        check("t4_timeout_err", 32'(timeout_err), 1);
        check("t4_ch2_kept", 32'(samples[23:12]), 770);

        // Foreign channel ignored while waiting on ch1; matching response coincides with a frame tick.
        respond(5'd3, 12'd4000, 1'b0);
        repeat (2) step();
        check("t5_stays_wait", 32'(cmd_valid), 0);
        check("t5_ch1_unchanged", 32'(samples[11:0]), 1500);
        respond(5'd1, 12'd2100, 1'b1);
        check("t5_ch1_accepted", 32'(samples[11:0]), 2100);
        check("t5_snap_pre_update_pos", 32'(dir_pos), 0);
        check("t5_snap_stale", 32'(stale), 2'b10);
        step();
        snap(2'b01, 2'b00, 2'b10, "t5_next_snap");
        check("t4_err_sticky", 32'(timeout_err), 1);

        // Back-to-back frame ticks keep the strobe high.
        new_frame = 1'b1;
        step();
        check("bb_strobe_1", 32'(frame_strobe), 1);
        step();
        new_frame = 1'b0;
        check("bb_strobe_2", 32'(frame_strobe), 1);
        check("bb_stale_all", 32'(stale), 2'b11);
        step();
        check("bb_strobe_off", 32'(frame_strobe), 0);

        // Reset mid-WAIT drops the in-flight response.
        issue(5'd2, "t6_issue_ch2");
        reset = 1'b1;
        step();
        respond(5'd2, 12'd123, 1'b0);
        check_all_zero("t6_reset");
        reset = 1'b0;
        step();
        check("t6_restart_valid", 32'(cmd_valid), 1);
        check("t6_restart_ch", 32'(cmd_channel), 1);
        check("t6_ch2_dropped", 32'(samples[23:12]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
